// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and bubble value.
// The optional skid slot is enabled by the PIPE_STAGE_SKID_EN macro (see pipe_stage_reg).
package pipe_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    // An empty stage presents an all-zero payload, which decodes as a NOP downstream.
    localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, synchronous active-low reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush and a blocked-output cycle counter.
// Define PIPE_STAGE_SKID_EN to add a skid slot with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [DATA_W-1:0] BUBBLE = {DATA_W{BUBBLE_BIT}};

    stage_state_e      state;
    logic [DATA_W-1:0] main_data;
    logic              accept;
    logic              emit;
    logic              out_blocked;

    assign emit        = out_valid && out_ready && !stall;
    assign accept      = in_valid && in_ready;
    assign out_blocked = out_valid && !(out_ready && !stall);
    assign out_data    = main_data;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data;
    logic              in_ready_q;

    assign in_ready = in_ready_q;

    // Main slot drives the output; the skid slot absorbs one payload while the output is blocked.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state      <= ST_EMPTY;
            main_data  <= BUBBLE;
            skid_data  <= BUBBLE;
            out_valid  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_FULL;
                        main_data <= in_data;
                        out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && emit) begin
                        main_data <= in_data;
                    end else if (accept) begin
                        state      <= ST_SKID;
                        skid_data  <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (emit) begin
                        state     <= ST_EMPTY;
                        main_data <= BUBBLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (emit) begin
                        state      <= ST_FULL;
                        main_data  <= skid_data;
                        skid_data  <= BUBBLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    main_data  <= BUBBLE;
                    skid_data  <= BUBBLE;
                    out_valid  <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    // Without a skid slot the stage can only refill in the cycle it empties.
    assign in_ready = !out_valid || (out_ready && !stall);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state     <= ST_EMPTY;
            main_data <= BUBBLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_FULL;
                        main_data <= in_data;
                        out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        main_data <= in_data;
                    end else if (emit) begin
                        state     <= ST_EMPTY;
                        main_data <= BUBBLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    main_data <= BUBBLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
`endif

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_blocked),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg; a scoreboard monitor tracks payload order and occupancy.
// Expectations follow PIPE_STAGE_SKID_EN when it is defined for the build.
module tb_pipe_stage_reg;

    localparam int unsigned DW  = 96;
    localparam int unsigned CW  = 16;
    localparam int unsigned DW4 = 8;
    localparam int unsigned CW4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          stall;
    logic          flush;
    logic [CW-1:0] stall_cnt;

    logic           rst4_n;
    logic           in_valid4;
    logic           in_ready4;
    logic [DW4-1:0] in_data4;
    logic           out_valid4;
    logic           out_ready4;
    logic [DW4-1:0] out_data4;
    logic           stall4;
    logic           flush4;
    logic [CW4-1:0] stall_cnt4;

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall     (stall),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW4), .CNT_W(CW4)) dut4 (
        .clk       (clk),
        .rst_n     (rst4_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .stall     (stall4),
        .flush     (flush4),
        .stall_cnt (stall_cnt4)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [DW-1:0] sb_q[$];
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_ready;

    // Scoreboard: checks outputs just before each rising edge, then models that edge.
    always @(negedge clk) begin
        #4;
        exp_valid = (sb_q.size() != 0);
        exp_data  = exp_valid ? sb_q[0] : '0;
`ifdef PIPE_STAGE_SKID_EN
        exp_ready = (sb_q.size() < 2);
`else
        exp_ready = !exp_valid || (out_ready && !stall);
`endif
        if (mon_en) begin
            n_checks++;
            if (out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL sb_out_valid t=%0t: got %b expected %b", $time, out_valid, exp_valid);
            end
            n_checks++;
            if (out_data !== exp_data) begin
                n_fail++;
                $display("FAIL sb_out_data t=%0t: got %h expected %h", $time, out_data, exp_data);
            end
            n_checks++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL sb_in_ready t=%0t: got %b expected %b", $time, in_ready, exp_ready);
            end
            n_checks++;
            if (stall_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL sb_stall_cnt t=%0t: got %0d expected %0d", $time, stall_cnt, exp_cnt);
            end
        end
        if (!rst_n) begin
            sb_q.delete();
            exp_cnt = '0;
        end else begin
            if (exp_valid && !(out_ready && !stall) && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
            if (flush) begin
                sb_q.delete();
            end else begin
                if (exp_valid && out_ready && !stall) void'(sb_q.pop_front());
                if (in_valid && exp_ready) sb_q.push_back(in_data);
            end
        end
    end

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++;
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        idle_inputs();
        in_valid  = 1'b1;
        in_data   = DW'(8'h13);
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (out_data !== DW'(8'h13)) begin n_fail++; $display("FAIL basic_data: got %h expected 13", out_data); end
        n_checks++;
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL basic_stall_cnt: got %0d expected 0", stall_cnt); end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_skid();
        idle_inputs();
        in_valid = 1'b1;
        in_data  = DW'(8'h11);
        @(negedge clk);
        in_data = DW'(8'h22);
        #1;
        n_checks++;
`ifdef PIPE_STAGE_SKID_EN
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_full: got %b expected 1", in_ready); end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_ready_skid: got %b expected 0", in_ready); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
`else
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_ready_blocked: got %b expected 0", in_ready); end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_flow: got %b expected 1", in_ready); end
`endif
        n_checks++;
        if (out_data !== DW'(8'h11)) begin n_fail++; $display("FAIL skid_first: got %h expected 11", out_data); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_data !== DW'(8'h22)) begin n_fail++; $display("FAIL skid_second: got %h expected 22", out_data); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 1'b1;
        in_data  = DW'(8'h44);
        @(negedge clk);
        in_data = DW'(8'h55);
        @(negedge clk);
        flush   = 1'b1;
        in_data = DW'(8'h33);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_data !== '0) begin n_fail++; $display("FAIL flush_data: got %h expected 0", out_data); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        in_valid = 1'b1;
        in_data  = DW'(8'hA1);
        @(negedge clk);
        in_data = DW'(8'hA2);
        @(negedge clk);
        rst_n     = 1'b0;
        flush     = 1'b1;
        stall     = 1'b1;
        out_ready = 1'b1;
        in_data   = DW'(8'hA3);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", stall_cnt); end
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (out_data !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", out_data); end
    endtask

    task automatic test_stall();
        idle_inputs();
        in_valid  = 1'b1;
        in_data   = DW'(8'h66);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        stall    = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_data !== DW'(8'h66)) begin n_fail++; $display("FAIL stall_hold%0d: got %h expected 66", i, out_data); end
        end
        n_checks++;
        if (stall_cnt !== CW'(5)) begin n_fail++; $display("FAIL stall_cnt5: got %0d expected 5", stall_cnt); end
        stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_emit: got %b expected 0", out_valid); end
        n_checks++;
        if (stall_cnt !== CW'(5)) begin n_fail++; $display("FAIL stall_cnt_after: got %0d expected 5", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d        = DW'(i * 17 + 1);
            in_valid = 1'b1;
            in_data  = d;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready); end
            @(negedge clk);
            n_checks++;
            if (out_data !== d) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", i, out_data, d); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL random_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_saturate();
        rst4_n = 1'b0;
        @(negedge clk);
        rst4_n = 1'b1;
        n_checks++;
        if (stall_cnt4 !== '0) begin n_fail++; $display("FAIL sat_reset: got %0d expected 0", stall_cnt4); end
        n_checks++;
        if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL sat_ready: got %b expected 1", in_ready4); end
        in_valid4 = 1'b1;
        in_data4  = 8'h5A;
        @(negedge clk);
        in_valid4 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (stall_cnt4 !== CW4'((i < 15) ? i : 15)) begin
                n_fail++;
                $display("FAIL sat_cnt%0d: got %0d expected %0d", i, stall_cnt4, (i < 15) ? i : 15);
            end
        end
        n_checks++;
        if (out_data4 !== 8'h5A) begin n_fail++; $display("FAIL sat_hold: got %h expected 5a", out_data4); end
        flush4 = 1'b1;
        @(negedge clk);
        flush4 = 1'b0;
        n_checks++;
        if (stall_cnt4 !== CW4'(15)) begin n_fail++; $display("FAIL sat_flush_cnt: got %0d expected 15", stall_cnt4); end
        n_checks++;
        if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL sat_flush_valid: got %b expected 0", out_valid4); end
    endtask

    initial begin
        rst4_n     = 1'b0;
        in_valid4  = 1'b0;
        in_data4   = '0;
        out_ready4 = 1'b0;
        stall4     = 1'b0;
        flush4     = 1'b0;
        test_reset();
        test_basic();
        test_skid();
        test_flush();
        test_reset_mid();
        test_reset();
        test_stall();
        test_back_to_back();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, meaning payload width (inst + pc4 + pc).
REQ-002 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-003 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have ports: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: in_valid  input  1  upstream payload valid.
REQ-006 SHALL have ports: in_ready  output  1  stage accepts payload this cycle.
REQ-007 SHALL have ports: in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have ports: out_valid  output  1  downstream payload valid.
REQ-009 SHALL have ports: out_ready  input  1  downstream accepts payload.
REQ-010 SHALL have ports: out_data  output  DATA_W  downstream payload.
REQ-011 SHALL have ports: stall  input  1  hold request (data hazard); blocks output transfer.
REQ-012 SHALL have ports: flush  input  1  kill request (control hazard); empties stage.
REQ-013 SHALL have ports: stall_cnt  output  CNT_W  saturating count of blocked-output cycles.

Function
REQ-014 SHALL define accept = in_valid && in_ready; define emit = out_valid && out_ready && !stall.
REQ-015 SHALL hold main slot and skid slot, each with valid bit; states EMPTY (none valid), FULL (main only), SKID (both valid).
REQ-016 SHALL transition: EMPTY->FULL on accept; FULL->EMPTY on emit && !accept; FULL->SKID on accept && !emit; FULL stays FULL on accept && emit (main reloaded); SKID->FULL on emit (skid moves to main).
REQ-017 SHALL drive in_ready = !skid_valid, from registered state only; in_ready=1 in EMPTY and FULL, 0 in SKID.
REQ-018 SHALL present main slot on out_data with one-cycle latency (data accepted in cycle N visible in N+1 when stage was EMPTY).
REQ-019 SHALL drive out_data = 0 whenever out_valid = 0 (bubble = all-zero NOP).
REQ-020 SHALL preserve order: skid contents always emitted before any later accepted payload.
REQ-021 SHALL, on flush=1, enter EMPTY next cycle and zero both slots; payload accepted in the same cycle is discarded; flush overrides stall, emit and accept.
REQ-022 SHALL hold all slot contents unchanged while stall=1 (emit suppressed), accepting only into free slots.
REQ-023 SHALL increment stall_cnt each cycle out_valid && !(out_ready && !stall); saturate at all-ones, never wrap; flush does not clear it.

Reset
REQ-024 SHALL on rst_n=0 at a clock edge: state EMPTY, both slots zero, out_valid=0, out_data=0, stall_cnt=0, in_ready=1 next cycle.
REQ-025 SHALL give reset priority over flush, stall and all handshakes, including mid-transfer in SKID state.

Configuration
REQ-026 SHALL use macro PIPE_STAGE_SKID_EN: defined -> skid slot and SKID state present, in_ready registered per REQ-017.
REQ-027 SHALL, when PIPE_STAGE_SKID_EN undefined, omit skid slot; SKID unreachable; in_ready = !out_valid || (out_ready && !stall) (combinational); all other requirements unchanged.

Structure
REQ-028 SHALL place state encoding (EMPTY/FULL/SKID, 2 bits) and bubble constant in shared package pipe_pkg.
REQ-029 SHALL implement saturating counter as sub-module sat_counter (parameter CNT_W; inputs clk, rst_n, inc; output count).

Verification
REQ-030 SHALL test: rst_n=0 one cycle then in_valid=1, in_data=0x...0013, out_ready=1 -> out_valid=1, out_data=0x...0013 next cycle, stall_cnt=0.
REQ-031 SHALL test: FULL with A=0x11, out_ready=0, accept B=0x22 -> SKID, in_ready=0; raise out_ready -> out_data A then B on consecutive cycles.
REQ-032 SHALL test: SKID state, flush=1 with in_valid=1 data 0x33 -> next cycle out_valid=0, out_data=0, in_ready=1, 0x33 never emitted.
REQ-033 SHALL test: out_valid=1, out_ready=1, stall=1 for 5 cycles -> out_data constant, stall_cnt=5; stall=0 -> emit once.
REQ-034 SHALL test: CNT_W=4, blocked 20 cycles -> stall_cnt=15 and holds.
REQ-035 SHALL test: both macro settings; without PIPE_STAGE_SKID_EN, out_valid=1, out_ready=1, stall=0 -> in_ready=1 same cycle, back-to-back throughput 1/cycle.
